id_ex: RTL

ID_EX -- requirements
Module: id_ex

---
 rtl/id_ex_if.sv | 46 ++++
 rtl/id_ex.sv | 95 +++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID->EX pipeline bus: decoded fields from id, registered copies to ex,
// plus the ex-side control inputs and the load-use stall back to the front end.
interface id_ex_if;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic [4:0]  reg1_r_addr_i;
  logic [4:0]  reg2_r_addr_i;
  logic [31:0] reg1_r_data_i;
  logic [31:0] reg2_r_data_i;
  logic        reg_w_ena_i;
  logic [4:0]  reg_w_addr_i;
  logic        mem_w_ena_i;
  logic        mem_r_ena_i;
  logic        ex_jump_ena_i;
  logic        hold_i;

  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [4:0]  reg1_r_addr_o;
  logic [4:0]  reg2_r_addr_o;
  logic [31:0] reg1_r_data_o;
  logic [31:0] reg2_r_data_o;
  logic        reg_w_ena_o;
  logic [4:0]  reg_w_addr_o;
  logic        mem_w_ena_o;
  logic        mem_r_ena_o;
  logic        load_use_stall_o;

  modport master (
    output inst_i, inst_addr_i, reg1_r_addr_i, reg2_r_addr_i,
           reg1_r_data_i, reg2_r_data_i, reg_w_ena_i, reg_w_addr_i,
           mem_w_ena_i, mem_r_ena_i, ex_jump_ena_i, hold_i,
    input  inst_o, inst_addr_o, reg1_r_addr_o, reg2_r_addr_o,
           reg1_r_data_o, reg2_r_data_o, reg_w_ena_o, reg_w_addr_o,
           mem_w_ena_o, mem_r_ena_o, load_use_stall_o
  );

  modport slave (
    input  inst_i, inst_addr_i, reg1_r_addr_i, reg2_r_addr_i,
           reg1_r_data_i, reg2_r_data_i, reg_w_ena_i, reg_w_addr_i,
           mem_w_ena_i, mem_r_ena_i, ex_jump_ena_i, hold_i,
    output inst_o, inst_addr_o, reg1_r_addr_o, reg2_r_addr_o,
           reg1_r_data_o, reg2_r_data_o, reg_w_ena_o, reg_w_addr_o,
           mem_w_ena_o, mem_r_ena_o, load_use_stall_o
  );
endinterface

// File: rtl/id_ex.sv
// ID/EX pipeline register with flush > hold > bubble > load priority.
// Load-use hazard detection and bubble insertion are built only with ID_EX_LOAD_USE_EN.
module id_ex (
  input  logic   clk,
  input  logic   rst_n,
  id_ex_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic [4:0]  reg1_r_addr;
    logic [4:0]  reg2_r_addr;
    logic [31:0] reg1_r_data;
    logic [31:0] reg2_r_data;
    logic        reg_w_ena;
    logic [4:0]  reg_w_addr;
    logic        mem_w_ena;
    logic        mem_r_ena;
  } pipe_t;

  localparam pipe_t BUBBLE = pipe_t'{NOP, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0,
                                     1'b0, 5'd0, 1'b0, 1'b0};

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_FLUSH
  } action_e;

  pipe_t   pipe_q;
  pipe_t   pipe_d;
  pipe_t   in_w;
  action_e act;
  logic    stall;

  always_comb begin
    in_w = pipe_t'{bus.inst_i, bus.inst_addr_i, bus.reg1_r_addr_i, bus.reg2_r_addr_i,
                   bus.reg1_r_data_i, bus.reg2_r_data_i, bus.reg_w_ena_i,
                   bus.reg_w_addr_i, bus.mem_w_ena_i, bus.mem_r_ena_i};
  end

`ifdef ID_EX_LOAD_USE_EN
  logic hazard;

  // A load in ex whose rd (never x0) is a source of the instruction in id.
  always_comb begin
    hazard = pipe_q.mem_r_ena && pipe_q.reg_w_ena && (pipe_q.reg_w_addr != '0) &&
             ((bus.reg1_r_addr_i == pipe_q.reg_w_addr) ||
              (bus.reg2_r_addr_i == pipe_q.reg_w_addr));
    stall  = hazard && !bus.ex_jump_ena_i && !bus.hold_i;
  end
`else
  always_comb begin
    stall = 1'b0;
  end
`endif

  always_comb begin
    act = ACT_LOAD;
    if (bus.ex_jump_ena_i)  act = ACT_FLUSH;
    else if (bus.hold_i)    act = ACT_HOLD;
    else if (stall)         act = ACT_BUBBLE;
  end

  always_comb begin
    pipe_d = pipe_q;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: pipe_d = BUBBLE;
      ACT_HOLD:              pipe_d = pipe_q;
      default:               pipe_d = in_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= BUBBLE;
    else        pipe_q <= pipe_d;
  end

  assign bus.inst_o           = pipe_q.inst;
  assign bus.inst_addr_o      = pipe_q.inst_addr;
  assign bus.reg1_r_addr_o    = pipe_q.reg1_r_addr;
  assign bus.reg2_r_addr_o    = pipe_q.reg2_r_addr;
  assign bus.reg1_r_data_o    = pipe_q.reg1_r_data;
  assign bus.reg2_r_data_o    = pipe_q.reg2_r_data;
  assign bus.reg_w_ena_o      = pipe_q.reg_w_ena;
  assign bus.reg_w_addr_o     = pipe_q.reg_w_addr;
  assign bus.mem_w_ena_o      = pipe_q.mem_w_ena;
  assign bus.mem_r_ena_o      = pipe_q.mem_r_ena;
  assign bus.load_use_stall_o = stall;

endmodule
